// File: rtl/hsi_m_tx_arb.sv
// Transmit-message arbiter: fixed-priority grant with age-based promotion,
// per-message timeout and a mandatory inter-message gap.
module hsi_m_tx_arb #(
  parameter int unsigned GAP_TICKS   = 5000,
  parameter int unsigned AGE_LIMIT   = 8,
  parameter int unsigned MSG_TIMEOUT = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] req,
  input  logic [4:0] req_en,
  input  logic       pre_tm,
  input  logic       msg_end,
  output logic [4:0] grant,
  output logic       busy,
  output logic       gap,
  output logic [2:0] last_grant,
  output logic       timeout
);

  localparam int unsigned N_REQ = 5;
  localparam int unsigned TO_W  = $clog2(MSG_TIMEOUT);
  localparam int unsigned GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(MSG_TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TICKS - 1);
  localparam logic [3:0]       AGE_MAX  = 4'(AGE_LIMIT);
  localparam logic [2:0]       NO_GRANT = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       grant_q, grant_d;
  logic             busy_q, busy_d;
  logic             gap_q, gap_d;
  logic             timeout_q, timeout_d;
  logic [2:0]       last_q, last_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [3:0]       age_q [N_REQ];
  logic [3:0]       age_d [N_REQ];

  logic [4:0] eligible_c;
  logic [4:0] promoted_c;
  logic [4:0] sel_c;
  logic [4:0] pick_c;

  // Index of the single set bit of a one-hot vector.
  function automatic logic [2:0] onehot_idx(input logic [4:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < N_REQ; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Promoted requesters win over plain priority; lowest index wins within a class.
  always_comb begin
    eligible_c = req & req_en & {~pre_tm, 4'b1111};
    promoted_c = '0;
    for (int i = 0; i < N_REQ; i++) begin
      promoted_c[i] = eligible_c[i] && (age_q[i] == AGE_MAX);
    end
    sel_c  = (|promoted_c) ? promoted_c : eligible_c;
    pick_c = sel_c & 5'(~sel_c + 5'd1);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    timeout_d = 1'b0;
    last_d    = last_q;
    to_cnt_d  = to_cnt_q;
    gap_cnt_d = gap_cnt_q;
    for (int i = 0; i < N_REQ; i++) age_d[i] = age_q[i];

    case (state_q)
      S_IDLE: begin
        if (|eligible_c) begin
          state_d  = S_BUSY;
          grant_d  = pick_c;
          last_d   = onehot_idx(pick_c);
          to_cnt_d = '0;
          for (int i = 0; i < N_REQ; i++) begin
            if (pick_c[i])          age_d[i] = 4'd0;
            else if (eligible_c[i]) age_d[i] = (age_q[i] == AGE_MAX) ? AGE_MAX
                                                                     : 4'(age_q[i] + 4'd1);
            else                    age_d[i] = 4'd0;
          end
        end
      end
      S_BUSY: begin
        // A completed message takes precedence over a coincident timeout.
        if (msg_end) begin
          state_d   = S_GAP;
          grant_d   = '0;
          gap_cnt_d = '0;
        end else if (to_cnt_q == TO_LAST) begin
          state_d   = S_GAP;
          grant_d   = '0;
          timeout_d = 1'b1;
          gap_cnt_d = '0;
        end else begin
          to_cnt_d = TO_W'(to_cnt_q + TO_W'(1));
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = S_IDLE;
        else                       gap_cnt_d = GAP_W'(gap_cnt_q + GAP_W'(1));
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    gap_d  = (state_d == S_GAP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      gap_q     <= 1'b0;
      timeout_q <= 1'b0;
      last_q    <= NO_GRANT;
      to_cnt_q  <= '0;
      gap_cnt_q <= '0;
      for (int i = 0; i < N_REQ; i++) age_q[i] <= 4'd0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      gap_q     <= gap_d;
      timeout_q <= timeout_d;
      last_q    <= last_d;
      to_cnt_q  <= to_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      for (int i = 0; i < N_REQ; i++) age_q[i] <= age_d[i];
    end
  end

  assign grant      = grant_q;
  assign busy       = busy_q;
  assign gap        = gap_q;
  assign last_grant = last_q;
  assign timeout    = timeout_q;

endmodule
